// File: rtl/vdp_vram_host_write_scheduler_pkg.sv
// vdp_vram_host_write_scheduler_pkg: shared state encodings, bank masks and reset constants
package vdp_vram_host_write_scheduler_pkg;
  typedef enum logic {ST_IDLE, ST_FILL} state_t;
  localparam logic [1:0] BANK_EVEN_MASK = 2'b01;
  localparam logic [1:0] BANK_ODD_MASK  = 2'b10;
  localparam logic [7:0] INCR_RESET     = 8'd1;
  function automatic logic [1:0] bank_mask(input logic odd);
    return odd ? BANK_ODD_MASK : BANK_EVEN_MASK;
  endfunction
endpackage

// File: rtl/vdp_sync_fifo.sv
// vdp_sync_fifo: register-based synchronous FIFO exposing its head entry
module vdp_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [AW:0]      r_level;
  logic             w_push, w_pop;
  assign o_full  = r_level == (AW+1)'(DEPTH);
  assign o_empty = r_level == '0;
  assign o_level = r_level;
  assign o_head  = r_mem[r_rd];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_wdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/vdp_vram_host_write_scheduler.sv
// vdp_vram_host_write_scheduler: queues host writes and fill bursts, retiring the head
// only when the arbiter's host slot really reaches VRAM.
module vdp_vram_host_write_scheduler
  import vdp_vram_host_write_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_host_addr_write,
  input  logic [14:0]   i_host_addr,
  input  logic          i_host_incr_write,
  input  logic [7:0]    i_host_incr,
  input  logic          i_host_data_valid,
  output logic          o_host_data_ready,
  input  logic [15:0]   i_host_data,
  input  logic          i_host_fill_start,
  input  logic [14:0]   i_host_fill_count,
  input  logic [15:0]   i_host_fill_value,
  output logic          o_host_busy,
  output logic [LW-1:0] o_host_fifo_level,
  input  logic          i_vram_written,
  input  logic          i_affine_needs_vram,
  output logic [13:0]   o_vram_write_address_16b,
  output logic [15:0]   o_vram_write_data_16b,
  output logic [1:0]    o_vram_port_write_en_mask
);
  state_t      r_state, w_state_nx;
  logic [14:0] r_addr, r_remain, w_remain_nx, w_addr_cur;
  logic [7:0]  r_incr, w_incr_cur;
  logic [15:0] r_fill_value;
  logic [31:0] w_head, w_push_data;
  logic        w_idle, w_full, w_empty, w_accept, w_fill_push, w_push, w_pop, w_fill_go;
  assign w_idle      = r_state == ST_IDLE;
  assign w_addr_cur  = (w_idle && i_host_addr_write) ? i_host_addr : r_addr;
  assign w_incr_cur  = (w_idle && i_host_incr_write) ? i_host_incr : r_incr;
  assign w_fill_go   = w_idle && i_host_fill_start && i_host_fill_count != '0;
  assign o_host_data_ready = w_idle && !w_full;
  assign w_accept    = i_host_data_valid && o_host_data_ready;
  assign w_fill_push = !w_idle && !w_full;
  assign w_push      = w_accept || w_fill_push;
  // Affine owns the bus on suppressed slots, so the head stays put and retries.
  assign w_pop       = i_vram_written && !i_affine_needs_vram && !w_empty;
  assign w_push_data = {w_addr_cur[14:1], bank_mask(w_addr_cur[0]), w_idle ? i_host_data : r_fill_value};
  vdp_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_host_fifo_level)
  );
  assign o_host_busy               = !w_idle || !w_empty;
  assign o_vram_write_address_16b  = w_empty ? '0 : w_head[31:18];
  assign o_vram_port_write_en_mask = w_empty ? '0 : w_head[17:16];
  assign o_vram_write_data_16b     = w_empty ? '0 : w_head[15:0];
  always_comb begin
    w_state_nx  = r_state;
    w_remain_nx = r_remain;
    if (w_fill_go) begin
      w_state_nx  = ST_FILL;
      w_remain_nx = i_host_fill_count;
    end else if (w_fill_push) begin
      w_remain_nx = r_remain - 15'd1;
      w_state_nx  = (r_remain == 15'd1) ? ST_IDLE : ST_FILL;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_incr       <= INCR_RESET;
      r_remain     <= '0;
      r_fill_value <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_remain <= w_remain_nx;
      r_incr   <= w_incr_cur;
      r_addr   <= w_push ? w_addr_cur + {7'd0, w_incr_cur} : w_addr_cur;
      if (w_fill_go) r_fill_value <= i_host_fill_value;
    end
  end
endmodule

// File: tb/tb_vdp_vram_host_write_scheduler.sv
// tb_vdp_vram_host_write_scheduler: directed vector table plus hand-written multi-cycle sequences
module tb_vdp_vram_host_write_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        aw = 0, iw = 0, valid = 0, fill = 0, written = 0, affine = 0;
  logic [14:0] addr = '0, fcount = '0;
  logic [7:0]  incr = '0;
  logic [15:0] data = '0, fvalue = '0;
  logic        ready, busy;
  logic [3:0]  level;
  logic [13:0] vaddr;
  logic [15:0] vdata;
  logic [1:0]  vmask;
  int          checks = 0, errors = 0;

  vdp_vram_host_write_scheduler #(.FIFO_DEPTH(8)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .i_host_addr_write         (aw),
    .i_host_addr               (addr),
    .i_host_incr_write         (iw),
    .i_host_incr               (incr),
    .i_host_data_valid         (valid),
    .o_host_data_ready         (ready),
    .i_host_data               (data),
    .i_host_fill_start         (fill),
    .i_host_fill_count         (fcount),
    .i_host_fill_value         (fvalue),
    .o_host_busy               (busy),
    .o_host_fifo_level         (level),
    .i_vram_written            (written),
    .i_affine_needs_vram       (affine),
    .o_vram_write_address_16b  (vaddr),
    .o_vram_write_data_16b     (vdata),
    .o_vram_port_write_en_mask (vmask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic aw; logic [14:0] a; logic iw; logic [7:0] inc;
    logic v; logic [15:0] d; logic w; logic af;
    logic e_rdy; logic [3:0] e_lvl; logic e_busy;
    logic [13:0] e_addr; logic [1:0] e_mask; logic [15:0] e_data;
  } vec_t;
  vec_t vt [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [13:0] a, input logic [1:0] m, input logic [15:0] d);
    check({tag, ".addr"}, 32'(vaddr), 32'(a));
    check({tag, ".mask"}, 32'(vmask), 32'(m));
    check({tag, ".data"}, 32'(vdata), 32'(d));
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".mask"}, 32'(vmask), 32'h0);
    check({tag, ".ready"}, 32'(ready), 32'h1);
    check({tag, ".busy"}, 32'(busy), 32'h0);
    check({tag, ".level"}, 32'(level), 32'h0);
  endtask

  initial begin
    vt[0] = '{1, 15'h0010, 1, 8'h01, 1, 16'hAAAA, 0, 0, 1, 4'd1, 1, 14'h0008, 2'b01, 16'hAAAA};
    vt[1] = '{0, 15'h0000, 0, 8'h00, 1, 16'hBBBB, 0, 0, 1, 4'd2, 1, 14'h0008, 2'b01, 16'hAAAA};
    vt[2] = '{0, 15'h0000, 0, 8'h00, 0, 16'h0000, 1, 0, 1, 4'd1, 1, 14'h0008, 2'b10, 16'hBBBB};
    vt[3] = '{0, 15'h0000, 0, 8'h00, 0, 16'h0000, 1, 1, 1, 4'd1, 1, 14'h0008, 2'b10, 16'hBBBB};
    vt[4] = '{0, 15'h0000, 0, 8'h00, 0, 16'h0000, 0, 0, 1, 4'd1, 1, 14'h0008, 2'b10, 16'hBBBB};
    vt[5] = '{0, 15'h0000, 0, 8'h00, 0, 16'h0000, 1, 0, 1, 4'd0, 0, 14'h0000, 2'b00, 16'h0000};
    vt[6] = '{1, 15'h0100, 1, 8'h40, 1, 16'h5555, 0, 0, 1, 4'd1, 1, 14'h0080, 2'b01, 16'h5555};
    vt[7] = '{0, 15'h0000, 0, 8'h00, 1, 16'h6666, 1, 0, 1, 4'd1, 1, 14'h00A0, 2'b01, 16'h6666};
    vt[8] = '{0, 15'h0000, 0, 8'h00, 0, 16'h0000, 1, 0, 1, 4'd0, 0, 14'h0000, 2'b00, 16'h0000};

    repeat (2) step();
    check_idle("reset");
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      aw = vt[i].aw; addr = vt[i].a; iw = vt[i].iw; incr = vt[i].inc;
      valid = vt[i].v; data = vt[i].d; written = vt[i].w; affine = vt[i].af;
      step();
      check($sformatf("vec%0d.ready", i), 32'(ready), 32'(vt[i].e_rdy));
      check($sformatf("vec%0d.level", i), 32'(level), 32'(vt[i].e_lvl));
      check($sformatf("vec%0d.busy", i), 32'(busy), 32'(vt[i].e_busy));
      check_head($sformatf("vec%0d", i), vt[i].e_addr, vt[i].e_mask, vt[i].e_data);
    end
    aw = 0; iw = 0; valid = 0; written = 0; affine = 0;

    // fill the queue with no slots, hold the 9th word until a pop frees room
    aw = 1; addr = 15'h0000; iw = 1; incr = 8'h01;
    for (int k = 0; k < 8; k++) begin
      valid = 1; data = 16'hC000 | 16'(k);
      step();
      aw = 0; iw = 0;
    end
    check("full.level", 32'(level), 32'd8);
    check("full.ready", 32'(ready), 32'h0);
    data = 16'hC008;
    repeat (2) step();
    check("held.level", 32'(level), 32'd8);
    written = 1;
    step();
    written = 0;
    check("pop1.level", 32'(level), 32'd7);
    check("pop1.ready", 32'(ready), 32'h1);
    check_head("pop1", 14'h0000, 2'b10, 16'hC001);
    step();
    valid = 0;
    check("ninth.level", 32'(level), 32'd8);
    for (int k = 1; k <= 8; k++) begin
      check_head($sformatf("drain%0d", k), 14'(k >> 1), (k % 2) ? 2'b10 : 2'b01, 16'hC000 | 16'(k));
      written = 1;
      step();
      written = 0;
    end
    check_idle("drained");

    // fill wrapping past the top of the address space; addr writes during FILL are ignored
    aw = 1; addr = 15'h7FFF; iw = 1; incr = 8'h01;
    fill = 1; fcount = 15'd3; fvalue = 16'h1234;
    step();
    fill = 0; iw = 0; addr = 15'h0123;
    check("fill0.ready", 32'(ready), 32'h0);
    check("fill0.busy", 32'(busy), 32'h1);
    check("fill0.level", 32'(level), 32'd0);
    step();
    aw = 0;
    check("fill1.level", 32'(level), 32'd1);
    check_head("fill1", 14'h3FFF, 2'b10, 16'h1234);
    step();
    check("fill2.level", 32'(level), 32'd2);
    check("fill2.ready", 32'(ready), 32'h0);
    step();
    check("fill3.level", 32'(level), 32'd3);
    check("fill3.ready", 32'(ready), 32'h1);
    written = 1;
    step();
    check_head("fpop1", 14'h0000, 2'b01, 16'h1234);
    step();
    check_head("fpop2", 14'h0000, 2'b10, 16'h1234);
    step();
    written = 0;
    check_idle("fpop3");

    fill = 1; fcount = 15'd0;
    step();
    fill = 0;
    check_idle("fill_zero");

    // asynchronous reset in the middle of a burst
    fill = 1; fcount = 15'd5;
    step();
    fill = 0;
    step();
    check("midfill.level", 32'(level), 32'd1);
    rst_n = 0;
    #1;
    check_idle("async_rst");
    step();
    check_idle("rst_next");
    rst_n = 1;
    step();
    check_idle("rst_release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
